// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer_pkg
// Brief    : State encoding, default parameters and helpers for the PLL
//            reset and lock supervisor.
// Revision : 1.0 - initial release
// ============================================================================
package pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam int c_DEF_RST_CYCLES    = 8;
    localparam int c_DEF_LOCK_TIMEOUT  = 1023;
    localparam int c_DEF_STABLE_CYCLES = 16;
    localparam int c_DEF_MAX_RETRIES   = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : 1-bit two-flop synchronizer with synchronous active-high clear.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : Drives PLL RST, qualifies LOCKED, retries on timeout and gates
//            the downstream reset until lock has been stable.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int RST_CYCLES    = c_DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = c_DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = c_DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = c_DEF_MAX_RETRIES
) (
    input  logic clk,
    input  logic cpu_reset,
    input  logic locked_in,
    output logic pll_rst,
    output logic sys_rst,
    output logic ready,
    output logic fail,
    output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] retry_count
);

    localparam int c_RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int c_CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0]   c_RST_LAST     = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0]   c_STABLE_LAST  = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY    = c_RETRY_W'(MAX_RETRIES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic [c_RETRY_W-1:0]  r_retry;
    logic [c_RETRY_W-1:0]  w_retry_nxt;
    logic                  w_locked_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (cpu_reset),
        .d   (locked_in),
        .q   (w_locked_s)
    );

    // Saturate instead of wrapping so a stuck state can never alias a terminal count.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_retry_nxt = r_retry;
        case (r_state)
            RESET_PLL: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock is checked before the timeout so a late lock is never retried.
                if (w_locked_s) begin
                    w_state_nxt = STABILIZE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_retry < c_MAX_RETRY) begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = RESET_PLL;
                    end else begin
                        w_state_nxt = FAIL;
                    end
                end
            end
            STABILIZE: begin
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                w_cnt_nxt = '0;
                if (!w_locked_s) begin
                    w_state_nxt = RESET_PLL;
                    w_retry_nxt = '0;
                end
            end
            FAIL: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = RESET_PLL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clk) begin
        if (cpu_reset) begin
            r_state <= RESET_PLL;
            r_cnt   <= '0;
            r_retry <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            fail    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
            pll_rst <= (w_state_nxt == RESET_PLL) || (w_state_nxt == FAIL);
            sys_rst <= (w_state_nxt != RUN);
            ready   <= (w_state_nxt == RUN);
            fail    <= (w_state_nxt == FAIL);
        end
    end

    assign retry_count = r_retry;

endmodule
`default_nettype wire
